// File: rtl/reg_file_32x32.sv
`timescale 1ns/1ps
// reg_file_32x32
// Thirty-two entry general-purpose register file with two synchronous read
// ports, one write port addressed by a one-hot select, same-edge write-to-read
// bypass, and register 0 hardwired to zero.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   wr_en      write request
//   wr_onehot  one-hot write select (bit i selects register i)
//   wr_data    write data
//   rd_en      read request for both ports
//   rd_addr_a  read address, port A
//   rd_addr_b  read address, port B
//   rd_data_a  registered read data, port A
//   rd_data_b  registered read data, port B
//   rd_valid   one-cycle pulse marking fresh read data
//   wr_err     one-cycle pulse flagging a write select that was not one-hot
module reg_file_32x32 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [31:0]           wr_onehot,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [4:0]            rd_addr_a,
   input  logic [4:0]            rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   output logic [DATA_WIDTH-1:0] rd_data_b,
   output logic                  rd_valid,
   output logic                  wr_err
);

   logic [DATA_WIDTH-1:0] regs [32];
   logic                  onehot_ok;
   logic                  legal_wr;
   logic [DATA_WIDTH-1:0] next_a;
   logic [DATA_WIDTH-1:0] next_b;

   // A select is one-hot when it is nonzero and clearing its lowest set bit
   // leaves nothing behind. Only a one-hot select may write or bypass.
   assign onehot_ok = (wr_onehot != 32'd0) &&
                      ((wr_onehot & (wr_onehot - 32'd1)) == 32'd0);
   assign legal_wr  = wr_en && onehot_ok;

   // Read-side value for each port: register 0 is always zero, a legal write
   // on this same edge to the addressed register wins over storage, and
   // otherwise the stored value is returned.
   always_comb begin
      next_a = regs[rd_addr_a];
      next_b = regs[rd_addr_b];
      if (legal_wr && wr_onehot[rd_addr_a]) begin
         next_a = wr_data;
      end
      if (legal_wr && wr_onehot[rd_addr_b]) begin
         next_b = wr_data;
      end
      if (rd_addr_a == 5'd0) begin
         next_a = '0;
      end
      if (rd_addr_b == 5'd0) begin
         next_b = '0;
      end
   end

   // Storage. Entry 0 is only ever cleared by reset, so it stays zero; a
   // select of bit 0 therefore quietly writes nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (legal_wr && wr_onehot[i]) begin
               regs[i] <= wr_data;
            end
         end
      end
   end

   // Output registers. Read data holds while rd_en is low; the valid and
   // error flags are single-cycle pulses reflecting the previous edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
         rd_valid  <= 1'b0;
         wr_err    <= 1'b0;
      end else begin
         if (rd_en) begin
            rd_data_a <= next_a;
            rd_data_b <= next_b;
         end
         rd_valid <= rd_en;
         wr_err   <= wr_en && !onehot_ok;
      end
   end

endmodule
